mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single external memory port between NUM_REQ requesters. The requesters are the Q load, K load, V load and O drain engines of the FlashAttention accelerator.
- Each cycle it picks one pending request round-robin and drives proc2mem_command/addr/data.
- It records the returned transaction tag of every accepted load. When mem2proc_data_tag comes back, it routes mem2proc_data to the requester that owns that tag.
- It sits between the per-buffer load/drain controllers and the memory model.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority after reset.
- STORE_MASK, 4'b1000, bit i=1 means requester i issues stores; otherwise it issues loads.
- ADDR_W, 32, address width.
- BLOCK_W, 64, memory block width.
- TAG_W, 4, memory tag width; tag 0 means "no transaction".
- MAX_OUTSTANDING, 15, cap on in-flight loads; must be ≤ 2^TAG_W-1.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_vld  in  NUM_REQ  request valid, one bit per requester
- req_addr  in  NUM_REQ*ADDR_W  flattened addresses; requester i occupies bits [i*ADDR_W +: ADDR_W]
- req_wdata  in  NUM_REQ*BLOCK_W  flattened store data (ignored for load requesters)
- req_rdy  out  NUM_REQ  one-hot acceptance strobe
- rsp_vld  out  NUM_REQ  one-hot load-return strobe
- rsp_data  out  BLOCK_W  returned block, shared by all requesters
- mem2proc_transaction_tag  in  TAG_W  nonzero means the command driven this cycle is accepted
- mem2proc_data  in  BLOCK_W  returned data
- mem2proc_data_tag  in  TAG_W  tag of the returned data; 0 means none
- proc2mem_command  out  2  MEM_NONE=0, MEM_LOAD=1, MEM_STORE=2
- proc2mem_addr  out  ADDR_W  address sent to memory
- proc2mem_data  out  BLOCK_W  store data sent to memory
- outstanding_cnt  out  TAG_W  number of in-flight loads
- busy  out  1  any req_vld high, or outstanding_cnt != 0
- err_unknown_tag  out  1  sticky: data returned for a tag with no valid entry

Behaviour:
- State: round-robin pointer rr_ptr (log2 NUM_REQ bits); tag table of 2^TAG_W entries, each {valid, owner id}; outstanding counter; sticky error flag.
- Reset: all of the above clear to 0, and all table entries become invalid. During rst and on the following cycle's outputs: proc2mem_command=MEM_NONE, proc2mem_addr=0, proc2mem_data=0, req_rdy=0, rsp_vld=0, rsp_data=0, outstanding_cnt=0, busy=0, err_unknown_tag=0.
- Eligibility: requester i is eligible if req_vld[i]=1, and, when it is a load requester (STORE_MASK[i]=0), outstanding_cnt < MAX_OUTSTANDING. Store requesters are never throttled.
- Grant (combinational):
  - Winner g = first eligible index searching rr_ptr, rr_ptr+1, … modulo NUM_REQ.
  - Drive proc2mem_command = STORE if STORE_MASK[g], else LOAD; proc2mem_addr = req_addr[g]; proc2mem_data = req_wdata[g] for stores, otherwise 0.
  - With no eligible requester: command=MEM_NONE, addr=0, data=0.
- Accept: the command is accepted iff command != NONE and mem2proc_transaction_tag != 0. On accept:
  - req_rdy[g]=1 in the same cycle (combinational from the memory tag).
  - rr_ptr <= g+1 modulo NUM_REQ. rr_ptr is unchanged on a rejected or NONE cycle.
  - For a load: table[tag] <= {1, g} and outstanding_cnt increments.
  - For a store: no table write; the transaction is complete.
- Reject (tag 0): req_rdy=0, and the requester must hold req_vld/addr/wdata stable. The same winner is re-presented next cycle unless a higher-priority requester becomes eligible.
- Return (mem2proc_data_tag=T, T!=0):
  - If table[T].valid: rsp_vld[owner]=1 and rsp_data=mem2proc_data in the same cycle (combinational); table[T].valid <= 0 and outstanding_cnt decrements.
  - Otherwise: rsp_vld=0 and err_unknown_tag <= 1.
  - There is no response backpressure; requesters must sink rsp_vld unconditionally.
- Simultaneous events:
  - A return and a load accept in the same cycle: outstanding_cnt is unchanged.
  - The same tag T returning and being newly allocated in the same cycle: the retire applies first, then the allocation, so the entry ends valid with the new owner.
  - At outstanding_cnt = MAX_OUTSTANDING with a return in the same cycle: loads stay ineligible that cycle (the cap check uses the registered count).
- Reset mid-operation: the table is flushed. Returns for pre-reset tags then hit invalid entries and set err_unknown_tag. Integration must therefore either quiesce memory before reset or ignore err after reset.
- rsp_data is 0 whenever no rsp_vld bit is high.

Test Plan:
- Single load: req_vld=4'b0001, addr=0x100, memory tag=3 → LOAD 0x100 and req_rdy=0001 the same cycle. Later data_tag=3, data=0xDEAD → rsp_vld=0001, rsp_data=0xDEAD; outstanding goes 1→0.
- Round-robin: req_vld=1111 held, tag always nonzero → grants follow requester order 0,1,2,3,0; requester 3 issues MEM_STORE with its wdata on proc2mem_data.
- Backpressure: req_vld=0010, tag=0 for 3 cycles, then 5 → command held LOAD with the same addr; req_rdy=0 for 3 cycles, then 0010; rr_ptr becomes 2.
- Cap: MAX_OUTSTANDING=2, two loads accepted with no returns → a third load gets command NONE while a pending store still issues. After one return, the load issues on the next cycle.
- Tag reuse: tag 5 returns for requester 1 in the same cycle that tag 5 is allocated to requester 2 → rsp_vld=0010; a later return of tag 5 gives rsp_vld=0100; outstanding count stays correct.
- Reset and error: assert rst with 2 loads outstanding, then data_tag=7 returns → rsp_vld=0, err_unknown_tag=1 and it stays 1; outstanding_cnt=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one external memory port between load/store engines,
// tracking outstanding load tags and steering returned data back to the owning engine.
module mem_port_arbiter #(
    parameter int unsigned          NUM_REQ         = 4,
    parameter logic [NUM_REQ-1:0]   STORE_MASK      = NUM_REQ'(4'b1000),
    parameter int unsigned          ADDR_W          = 32,
    parameter int unsigned          BLOCK_W         = 64,
    parameter int unsigned          TAG_W           = 4,
    parameter int unsigned          MAX_OUTSTANDING = 15
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_REQ-1:0]           req_vld,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_addr,
    input  logic [NUM_REQ*BLOCK_W-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]           req_rdy,
    output logic [NUM_REQ-1:0]           rsp_vld,
    output logic [BLOCK_W-1:0]           rsp_data,
    input  logic [TAG_W-1:0]             mem2proc_transaction_tag,
    input  logic [BLOCK_W-1:0]           mem2proc_data,
    input  logic [TAG_W-1:0]             mem2proc_data_tag,
    output logic [1:0]                   proc2mem_command,
    output logic [ADDR_W-1:0]            proc2mem_addr,
    output logic [BLOCK_W-1:0]           proc2mem_data,
    output logic [TAG_W-1:0]             outstanding_cnt,
    output logic                         busy,
    output logic                         err_unknown_tag
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TAGS  = 1 << TAG_W;

    localparam logic [1:0] MEM_NONE  = 2'd0;
    localparam logic [1:0] MEM_LOAD  = 2'd1;
    localparam logic [1:0] MEM_STORE = 2'd2;

    typedef struct packed {
        logic             valid;
        logic [PTR_W-1:0] owner;
    } tag_entry_t;

    tag_entry_t         tag_tbl [TAGS];
    tag_entry_t         ret_entry;
    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   next_ptr;
    logic [NUM_REQ-1:0] eligible;
    logic               gnt_found;
    logic               gnt_store;
    logic               load_room;
    logic               accept;
    logic               load_acc;
    logic               ret_hit;
    logic               ret_miss;

    // Cap uses the registered count, so a same-cycle return does not free a slot yet.
    assign load_room = outstanding_cnt < TAG_W'(MAX_OUTSTANDING);
    assign eligible  = req_vld & (STORE_MASK | {NUM_REQ{load_room}});

    always_comb begin
        int unsigned idx;
        gnt_found = 1'b0;
        gnt_idx   = '0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_ptr) + k) % NUM_REQ;
            if (!gnt_found && eligible[idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = PTR_W'(idx);
            end
        end
    end

    assign gnt_store = STORE_MASK[gnt_idx];
    assign next_ptr  = PTR_W'((32'(gnt_idx) + 32'd1) % NUM_REQ);
    assign accept    = !rst && gnt_found && (mem2proc_transaction_tag != '0);
    assign load_acc  = accept && !gnt_store;
    assign ret_entry = tag_tbl[mem2proc_data_tag];
    assign ret_hit   = !rst && (mem2proc_data_tag != '0) && ret_entry.valid;
    assign ret_miss  = !rst && (mem2proc_data_tag != '0) && !ret_entry.valid;
    assign busy      = !rst && ((|req_vld) || (outstanding_cnt != '0));

    // Memory command, acceptance strobe and response steering are same-cycle paths.
    always_comb begin
        proc2mem_command = MEM_NONE;
        proc2mem_addr    = '0;
        proc2mem_data    = '0;
        req_rdy          = '0;
        rsp_vld          = '0;
        rsp_data         = '0;
        if (!rst && gnt_found) begin
            proc2mem_command = gnt_store ? MEM_STORE : MEM_LOAD;
            proc2mem_addr    = req_addr[32'(gnt_idx)*ADDR_W +: ADDR_W];
            if (gnt_store) begin
                proc2mem_data = req_wdata[32'(gnt_idx)*BLOCK_W +: BLOCK_W];
            end
            if (accept) begin
                req_rdy[gnt_idx] = 1'b1;
            end
        end
        if (ret_hit) begin
            rsp_vld[ret_entry.owner] = 1'b1;
            rsp_data                 = mem2proc_data;
        end
    end

    // Retire is written before allocate so a recycled tag ends up owned by the new load.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr          <= '0;
            outstanding_cnt <= '0;
            err_unknown_tag <= 1'b0;
            for (int i = 0; i < int'(TAGS); i++) begin
                tag_tbl[i] <= '0;
            end
        end else begin
            if (accept) begin
                rr_ptr <= next_ptr;
            end
            if (ret_hit) begin
                tag_tbl[mem2proc_data_tag].valid <= 1'b0;
            end
            if (load_acc) begin
                tag_tbl[mem2proc_transaction_tag] <= '{valid: 1'b1, owner: gnt_idx};
            end
            if (ret_miss) begin
                err_unknown_tag <= 1'b1;
            end
            outstanding_cnt <= outstanding_cnt + TAG_W'(load_acc) - TAG_W'(ret_hit);
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: expected per-cycle port values are queued when
// stimulus is driven and popped when the DUT outputs are sampled.
module tb_mem_port_arbiter;

    localparam logic [1:0] NONE = 2'd0;
    localparam logic [1:0] LD   = 2'd1;
    localparam logic [1:0] ST   = 2'd2;

    logic         clk;
    logic         rst;
    logic [3:0]   req_vld;
    logic [127:0] req_addr;
    logic [255:0] req_wdata;
    logic [3:0]   req_rdy;
    logic [3:0]   rsp_vld;
    logic [63:0]  rsp_data;
    logic [3:0]   mem_tag;
    logic [63:0]  mem_data;
    logic [3:0]   data_tag;
    logic [1:0]   cmd;
    logic [31:0]  maddr;
    logic [63:0]  mdata;
    logic [3:0]   outstanding_cnt;
    logic         busy;
    logic         err_unknown_tag;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [1:0]  cmd;
        logic [31:0] addr;
        logic [63:0] data;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic [63:0] rdata;
        logic [3:0]  cnt;
        logic        err;
        logic        busy;
    } exp_t;

    exp_t exp_q[$];

    mem_port_arbiter #(
        .NUM_REQ(4),
        .STORE_MASK(4'b1000),
        .ADDR_W(32),
        .BLOCK_W(64),
        .TAG_W(4),
        .MAX_OUTSTANDING(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_vld(req_vld),
        .req_addr(req_addr),
        .req_wdata(req_wdata),
        .req_rdy(req_rdy),
        .rsp_vld(rsp_vld),
        .rsp_data(rsp_data),
        .mem2proc_transaction_tag(mem_tag),
        .mem2proc_data(mem_data),
        .mem2proc_data_tag(data_tag),
        .proc2mem_command(cmd),
        .proc2mem_addr(maddr),
        .proc2mem_data(mdata),
        .outstanding_cnt(outstanding_cnt),
        .busy(busy),
        .err_unknown_tag(err_unknown_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] addr_of(input int g);
        return 32'h100 * (g + 1);
    endfunction

    // One clock: drive inputs after the falling edge, sample before the rising edge.
    task automatic cycle(input string name, input logic [3:0] vld, input logic [3:0] mtag,
                         input logic [3:0] dtag, input logic [63:0] ddata,
                         input logic [1:0] e_cmd, input int e_g, input logic [3:0] e_rdy,
                         input logic [3:0] e_rsp, input logic [3:0] e_cnt, input logic e_err);
        exp_t e;
        exp_t o;
        e.cmd   = e_cmd;
        e.addr  = (e_cmd == NONE) ? 32'h0 : addr_of(e_g);
        e.data  = (e_cmd == ST) ? 64'hCAFE_F00D_0000_0003 : 64'h0;
        e.rdy   = e_rdy;
        e.rsp   = e_rsp;
        e.rdata = (e_rsp != 4'b0) ? ddata : 64'h0;
        e.cnt   = e_cnt;
        e.err   = e_err;
        e.busy  = (vld != 4'b0) || (e_cnt != 4'b0);
        exp_q.push_back(e);
        @(negedge clk);
        rst      = 1'b0;
        req_vld  = vld;
        mem_tag  = mtag;
        data_tag = dtag;
        mem_data = ddata;
        #1;
        o = exp_q.pop_front();
        check({name, ".cmd"},  64'(cmd), 64'(o.cmd));
        check({name, ".addr"}, 64'(maddr), 64'(o.addr));
        check({name, ".data"}, mdata, o.data);
        check({name, ".rdy"},  64'(req_rdy), 64'(o.rdy));
        check({name, ".rsp"},  64'(rsp_vld), 64'(o.rsp));
        check({name, ".rdata"}, rsp_data, o.rdata);
        check({name, ".cnt"},  64'(outstanding_cnt), 64'(o.cnt));
        check({name, ".err"},  64'(err_unknown_tag), 64'(o.err));
        check({name, ".busy"}, 64'(busy), 64'(o.busy));
    endtask

    initial begin
        rst      = 1'b1;
        req_vld  = '0;
        mem_tag  = '0;
        data_tag = '0;
        mem_data = '0;
        for (int i = 0; i < 4; i++) begin
            req_addr[i*32 +: 32]  = addr_of(i);
            req_wdata[i*64 +: 64] = 64'h1111_0000_0000_0000 * (i + 1);
        end
        req_wdata[3*64 +: 64] = 64'hCAFE_F00D_0000_0003;

        // Reset with requests and a live memory tag: nothing may be issued.
        @(negedge clk);
        req_vld = 4'b1111;
        mem_tag = 4'd1;
        #1;
        check("rst.cmd",  64'(cmd), 64'(NONE));
        check("rst.addr", 64'(maddr), 64'h0);
        check("rst.rdy",  64'(req_rdy), 64'h0);
        check("rst.rsp",  64'(rsp_vld), 64'h0);
        check("rst.busy", 64'(busy), 64'h0);
        check("rst.cnt",  64'(outstanding_cnt), 64'h0);
        check("rst.err",  64'(err_unknown_tag), 64'h0);

        // Round robin 0,1,2,3,0 with each load retired while the next is issued.
        cycle("rr0", 4'b1111, 4'd1, 4'd0, 64'h0,   LD, 0, 4'b0001, 4'b0000, 4'd0, 1'b0);
        cycle("rr1", 4'b1111, 4'd2, 4'd1, 64'hA1,  LD, 1, 4'b0010, 4'b0001, 4'd1, 1'b0);
        cycle("rr2", 4'b1111, 4'd3, 4'd2, 64'hA2,  LD, 2, 4'b0100, 4'b0010, 4'd1, 1'b0);
        cycle("rr3", 4'b1111, 4'd4, 4'd3, 64'hA3,  ST, 3, 4'b1000, 4'b0100, 4'd1, 1'b0);
        cycle("rr4", 4'b1111, 4'd5, 4'd0, 64'h0,   LD, 0, 4'b0001, 4'b0000, 4'd0, 1'b0);
        cycle("rr5", 4'b0000, 4'd0, 4'd5, 64'hA5,  NONE, 0, 4'b0000, 4'b0001, 4'd1, 1'b0);

        // Single load and its return.
        cycle("ld0", 4'b0001, 4'd3, 4'd0, 64'h0,    LD, 0, 4'b0001, 4'b0000, 4'd0, 1'b0);
        cycle("ld1", 4'b0000, 4'd0, 4'd0, 64'h0,    NONE, 0, 4'b0000, 4'b0000, 4'd1, 1'b0);
        cycle("ld2", 4'b0000, 4'd0, 4'd3, 64'hDEAD, NONE, 0, 4'b0000, 4'b0001, 4'd1, 1'b0);
        cycle("ld3", 4'b0000, 4'd0, 4'd0, 64'h0,    NONE, 0, 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Memory backpressure holds the command until a tag is given.
        for (int i = 0; i < 3; i++) begin
            cycle("bp", 4'b0010, 4'd0, 4'd0, 64'h0, LD, 1, 4'b0000, 4'b0000, 4'd0, 1'b0);
        end
        cycle("bp_acc", 4'b0010, 4'd5, 4'd0, 64'h0, LD, 1, 4'b0010, 4'b0000, 4'd0, 1'b0);
        // Pointer moved past requester 1, so requester 0 wins over 1.
        cycle("bp_ptr", 4'b0011, 4'd6, 4'd0, 64'h0, LD, 0, 4'b0001, 4'b0000, 4'd1, 1'b0);

        // At the cap loads stall while the store still issues.
        cycle("cap_st",  4'b1001, 4'd7, 4'd0, 64'h0,  ST, 3, 4'b1000, 4'b0000, 4'd2, 1'b0);
        cycle("cap_ld",  4'b0001, 4'd7, 4'd0, 64'h0,  NONE, 0, 4'b0000, 4'b0000, 4'd2, 1'b0);
        cycle("cap_ret", 4'b0001, 4'd7, 4'd6, 64'hB6, NONE, 0, 4'b0000, 4'b0001, 4'd2, 1'b0);
        cycle("cap_go",  4'b0001, 4'd7, 4'd0, 64'h0,  LD, 0, 4'b0001, 4'b0000, 4'd1, 1'b0);

        // Tag 5 retired for requester 1 and reallocated to requester 2 in one cycle.
        cycle("tr_ret7", 4'b0000, 4'd0, 4'd7, 64'hB7, NONE, 0, 4'b0000, 4'b0001, 4'd2, 1'b0);
        cycle("tr_swap", 4'b0100, 4'd5, 4'd5, 64'hB5, LD, 2, 4'b0100, 4'b0010, 4'd1, 1'b0);
        cycle("tr_ret5", 4'b0000, 4'd0, 4'd5, 64'hC5, NONE, 0, 4'b0000, 4'b0100, 4'd1, 1'b0);
        cycle("tr_idle", 4'b0000, 4'd0, 4'd0, 64'h0,  NONE, 0, 4'b0000, 4'b0000, 4'd0, 1'b0);

        // Reset with two loads in flight, then a stale return.
        cycle("re_l0", 4'b0001, 4'd8, 4'd0, 64'h0, LD, 0, 4'b0001, 4'b0000, 4'd0, 1'b0);
        cycle("re_l1", 4'b0010, 4'd9, 4'd0, 64'h0, LD, 1, 4'b0010, 4'b0000, 4'd1, 1'b0);
        @(negedge clk);
        rst     = 1'b1;
        req_vld = 4'b0000;
        mem_tag = 4'd0;
        #1;
        check("re_rst.cmd",  64'(cmd), 64'(NONE));
        check("re_rst.busy", 64'(busy), 64'h0);
        cycle("re_stale", 4'b0000, 4'd0, 4'd7, 64'hE7, NONE, 0, 4'b0000, 4'b0000, 4'd0, 1'b0);
        cycle("re_err",   4'b0000, 4'd0, 4'd0, 64'h0,  NONE, 0, 4'b0000, 4'b0000, 4'd0, 1'b1);
        cycle("re_stick", 4'b0000, 4'd0, 4'd0, 64'h0,  NONE, 0, 4'b0000, 4'b0000, 4'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
